// File: rtl/cpu_bus_dma_arbiter.sv
// cpu_bus_dma_arbiter
//   Owns the CPU memory bus. Muxes instruction fetch (IF), execute (IE) and
//   OAM DMA onto a single memory port. A CPU write to DMA_TRIG_ADDR starts a
//   256-byte copy {page,00..FF} -> OAM_DATA_ADDR while the CPU core is halted.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   if_*                IF side: bus_req selects IF (1) or IE (0), addr, read strobe
//   ie_*                IE side: addr, write data, write/read strobes
//   mem_data_in         read data returned by the memory system
//   mem_*               muxed bus outputs (combinational)
//   dma_halt            registered halt request to the CPU core
//   dma_busy            registered, high whenever the DMA FSM is not idle
module cpu_bus_dma_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned READ_LATENCY  = 2,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_bus_req,
    input  logic [15:0] if_addr,
    input  logic        if_read_en,
    input  logic [15:0] ie_addr,
    input  logic [7:0]  ie_data_out,
    input  logic        ie_write_en,
    input  logic        ie_read_en,
    input  logic [7:0]  mem_data_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic        dma_halt,
    output logic        dma_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ALIGN,
        S_READ,
        S_READ_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // READ_WAIT lasts READ_LATENCY-1 cycles; with latency 1 it is skipped.
    localparam int unsigned WAIT_CYCLES = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  WAIT_LAST   = 8'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        parity_q, parity_d;
    logic        halt_q, halt_d;
    logic        busy_q, busy_d;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_re;
    logic        trig;

    // CPU-side mux: IF never writes.
    always_comb begin
        cpu_addr = if_bus_req ? if_addr : ie_addr;
        cpu_dout = if_bus_req ? 8'h00 : ie_data_out;
        cpu_we   = ~if_bus_req & ie_write_en;
        cpu_re   = if_bus_req ? if_read_en : ie_read_en;
        trig     = cpu_we && (cpu_addr == DMA_TRIG_ADDR);
    end

    // Bus ownership: DMA only in READ/READ_WAIT/WRITE, so the trigger write
    // and any IE drain during SETTLE/ALIGN reach memory untouched.
    always_comb begin
        mem_addr     = cpu_addr;
        mem_data_out = cpu_dout;
        mem_write_en = cpu_we;
        mem_read_en  = cpu_re;
        unique case (state_q)
            S_READ: begin
                mem_addr     = {page_q, idx_q};
                mem_data_out = 8'h00;
                mem_write_en = 1'b0;
                mem_read_en  = 1'b1;
            end
            S_READ_WAIT: begin
                mem_addr     = {page_q, idx_q};
                mem_data_out = 8'h00;
                mem_write_en = 1'b0;
                mem_read_en  = 1'b0;
            end
            S_WRITE: begin
                mem_addr     = OAM_DATA_ADDR;
                mem_data_out = latch_q;
                mem_write_en = 1'b1;
                mem_read_en  = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        latch_d  = latch_q;
        cnt_d    = cnt_q;
        halt_d   = halt_q;
        parity_d = ~parity_q;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    cnt_d   = 8'h00;
                    halt_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 8'h00;
                    // An odd final settle cycle inserts ALIGN so the first
                    // READ always lands on the same parity phase.
                    state_d = parity_q ? S_ALIGN : S_READ;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                cnt_d = 8'h00;
                if (READ_LATENCY > 1) begin
                    state_d = S_READ_WAIT;
                end else begin
                    latch_d = mem_data_in;
                    state_d = S_WRITE;
                end
            end
            S_READ_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    latch_d = mem_data_in;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WRITE: begin
                if (idx_q == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                halt_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            latch_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            halt_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            halt_q   <= halt_d;
            busy_q   <= busy_d;
        end
    end

    assign dma_halt = halt_q;
    assign dma_busy = busy_q;

endmodule

// File: tb/tb_cpu_bus_dma_arbiter.sv
// tb_cpu_bus_dma_arbiter
//   Self-checking bench for cpu_bus_dma_arbiter: expected DMA read addresses
//   and $2004 write data are queued when a transfer is triggered and
//   popped by the bus monitor as the DUT issues them.
module tb_cpu_bus_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_bus_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_read_en = 1'b0;
    logic [15:0] ie_addr = '0;
    logic [7:0]  ie_data_out = '0;
    logic        ie_write_en = 1'b0;
    logic        ie_read_en = 1'b0;
    logic [7:0]  mem_data_in = '0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;
    logic        mem_read_en;
    logic        dma_halt;
    logic        dma_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [15:0] mon_ea;
    logic [7:0]  mon_ed;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        logic        re;
    } bus_exp_t;
    bus_exp_t bus_q[$];

    cpu_bus_dma_arbiter #(
        .SETTLE_CYCLES(2),
        .READ_LATENCY (2),
        .OAM_DATA_ADDR(16'h2004),
        .DMA_TRIG_ADDR(16'h4014)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_bus_req  (if_bus_req),
        .if_addr     (if_addr),
        .if_read_en  (if_read_en),
        .ie_addr     (ie_addr),
        .ie_data_out (ie_data_out),
        .ie_write_en (ie_write_en),
        .ie_read_en  (ie_read_en),
        .mem_data_in (mem_data_in),
        .mem_addr    (mem_addr),
        .mem_data_out(mem_data_out),
        .mem_write_en(mem_write_en),
        .mem_read_en (mem_read_en),
        .dma_halt    (dma_halt),
        .dma_busy    (dma_busy)
    );

    always #5 clk = ~clk;

    // Memory: registered read, data valid the cycle after the address.
    always @(posedge clk) mem_data_in <= mem[mem_addr];

    // Cycle index since reset release; bit 0 is the expected parity phase.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Scoreboard monitor for DMA reads and $2004 writes.
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (dma_busy && mem_read_en) begin
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dma_read_addr: got unexpected read of %h, required no read", mem_addr);
                end else begin
                    mon_ea = exp_addr_q.pop_front();
                    if (mem_addr !== mon_ea) begin
                        n_fail++;
                        $display("FAIL dma_read_addr: got %h, required %h", mem_addr, mon_ea);
                    end
                end
            end
            if (mem_write_en && mem_addr == 16'h2004) begin
                wr_count++;
                n_checks++;
                if (exp_data_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL oam_write_data: got unexpected write %h, required no write", mem_data_out);
                end else begin
                    mon_ed = exp_data_q.pop_front();
                    if (mem_data_out !== mon_ed) begin
                        n_fail++;
                        $display("FAIL oam_write_data: got %h, required %h", mem_data_out, mon_ed);
                    end
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b0;
        if_bus_req = 1'b0; if_read_en = 1'b0;
        ie_write_en = 1'b0; ie_read_en = 1'b0;
        exp_addr_q.delete(); exp_data_q.delete();
        wr_count = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_expect(input logic [7:0] page);
        for (int i = 0; i < 256; i++) begin
            exp_addr_q.push_back({page, 8'(i)});
            exp_data_q.push_back(mem[{page, 8'(i)}]);
        end
    endtask

    // Called at a negedge: drives one IE write across the next posedge.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        if_bus_req = 1'b0;
        ie_addr = a; ie_data_out = d; ie_write_en = 1'b1;
        @(posedge clk);
        #1 ie_write_en = 1'b0;
    endtask

    task automatic wait_dma(output int halt_len, output int first_rd, output bit tmo);
        int n;
        halt_len = 0; first_rd = -1; tmo = 1'b0; n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (dma_halt) halt_len++;
            if (mem_read_en && dma_busy && first_rd < 0) first_rd = n;
            if (!dma_halt && n > 1) break;
            if (n >= 2000) begin tmo = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ie_addr = 16'h1234; ie_data_out = 8'h5A; ie_write_en = 1'b0; if_bus_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dma_halt, dma_busy} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got halt/busy %b, required 00", {dma_halt, dma_busy});
        end
        n_checks++;
        if ({mem_addr, mem_data_out, mem_write_en} !== {16'h1234, 8'h5A, 1'b0}) begin
            n_fail++; $display("FAIL reset_bus: got %h/%h/%b, required 1234/5a/0", mem_addr, mem_data_out, mem_write_en);
        end
        rst = 1'b1;
    endtask

    task automatic run_trigger_test(input string name, input logic [7:0] page,
                                    input bit odd, input int exp_halt, input int exp_first);
        int hl, fr; bit tmo;
        reset_dut();
        load_expect(page);
        mon_en = 1'b1;
        @(negedge clk);
        if (cyc[0] != odd) @(negedge clk);
        if_bus_req = 1'b0;
        ie_addr = 16'h4014; ie_data_out = page; ie_write_en = 1'b1;
        #1;
        n_checks++;
        if ({mem_addr, mem_data_out, mem_write_en} !== {16'h4014, page, 1'b1}) begin
            n_fail++; $display("FAIL %s_trigger_pass: got %h/%h/%b, required 4014/%h/1", name, mem_addr, mem_data_out, mem_write_en, page);
        end
        @(posedge clk);
        #1 ie_write_en = 1'b0;
        wait_dma(hl, fr, tmo);
        n_checks++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got 1, required 0", name); end
        n_checks++;
        if (hl !== exp_halt) begin n_fail++; $display("FAIL %s_halt_len: got %0d, required %0d", name, hl, exp_halt); end
        n_checks++;
        if (fr !== exp_first) begin n_fail++; $display("FAIL %s_first_read: got %0d, required %0d", name, fr, exp_first); end
        n_checks++;
        if (wr_count !== 256) begin n_fail++; $display("FAIL %s_write_count: got %0d, required 256", name, wr_count); end
        n_checks++;
        if (exp_addr_q.size() + exp_data_q.size() !== 0) begin
            n_fail++; $display("FAIL %s_leftover: got %0d, required 0", name, exp_addr_q.size() + exp_data_q.size());
        end
        n_checks++;
        if (dma_busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_end: got %b, required 0", name, dma_busy); end
        mon_en = 1'b0;
    endtask

    task automatic test_xor_page();
        for (int i = 0; i < 256; i++) mem[16'h0300 + 16'(i)] = 8'(i) ^ 8'hA5;
        run_trigger_test("xor_page", 8'h03, 1'b0, 771, 3);
    endtask

    task automatic test_retrigger_ignored();
        int hl, fr, busy_after; bit tmo;
        reset_dut();
        load_expect(8'h02);
        mon_en = 1'b1;
        @(negedge clk);
        cpu_write(16'h4014, 8'h02);
        fork
            wait_dma(hl, fr, tmo);
            begin
                repeat (50) @(negedge clk);
                cpu_write(16'h4014, 8'h05);
            end
        join
        busy_after = 0;
        repeat (20) begin @(negedge clk); if (dma_busy) busy_after++; end
        n_checks++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL retrig_timeout: got 1, required 0"); end
        n_checks++;
        if (wr_count !== 256) begin n_fail++; $display("FAIL retrig_write_count: got %0d, required 256", wr_count); end
        n_checks++;
        if (busy_after !== 0) begin n_fail++; $display("FAIL retrig_restart: got %0d busy cycles, required 0", busy_after); end
        mon_en = 1'b0;
    endtask

    task automatic test_reset_abort();
        int n, late_wr, late_busy;
        reset_dut();
        load_expect(8'h02);
        mon_en = 1'b1;
        @(negedge clk);
        cpu_write(16'h4014, 8'h02);
        n = 0;
        while (wr_count < 100 && n < 1000) begin @(negedge clk); n++; end
        while (!mem_write_en && n < 1000) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 1000) begin n_fail++; $display("FAIL abort_reach_byte100: got timeout, required write seen"); end
        #2 mon_en = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({dma_halt, dma_busy, mem_write_en} !== 3'b000) begin
            n_fail++; $display("FAIL abort_outputs: got halt/busy/we %b, required 000", {dma_halt, dma_busy, mem_write_en});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        late_wr = 0; late_busy = 0;
        repeat (400) begin
            @(negedge clk);
            if (mem_write_en && mem_addr == 16'h2004) late_wr++;
            if (dma_busy) late_busy++;
        end
        n_checks++;
        if (late_wr !== 0) begin n_fail++; $display("FAIL abort_late_writes: got %0d, required 0", late_wr); end
        n_checks++;
        if (late_busy !== 0) begin n_fail++; $display("FAIL abort_late_busy: got %0d, required 0", late_busy); end
    endtask

    task automatic test_cpu_mux();
        bus_exp_t e;
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if_bus_req  = (i % 2 == 0);
            if_addr     = 16'h8000 + 16'(i);
            if_read_en  = 1'b1;
            ie_addr     = 16'h0010;
            ie_data_out = 8'h7E;
            ie_write_en = 1'b1;
            ie_read_en  = (i >= 4);
            if (i % 2 == 0) bus_q.push_back('{16'h8000 + 16'(i), 8'h00, 1'b0, 1'b1});
            else            bus_q.push_back('{16'h0010, 8'h7E, 1'b1, (i >= 4)});
            #1;
            e = bus_q.pop_front();
            n_checks++;
            if ({mem_addr, mem_data_out, mem_write_en, mem_read_en} !== {e.a, e.d, e.we, e.re}) begin
                n_fail++;
                $display("FAIL cpu_mux_%0d: got %h/%h/%b/%b, required %h/%h/%b/%b", i,
                         mem_addr, mem_data_out, mem_write_en, mem_read_en, e.a, e.d, e.we, e.re);
            end
        end
        @(negedge clk);
        ie_write_en = 1'b0; if_read_en = 1'b0; ie_read_en = 1'b0;
        n_checks++;
        if (dma_busy !== 1'b0) begin n_fail++; $display("FAIL cpu_mux_no_dma: got busy %b, required 0", dma_busy); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        run_trigger_test("even_trigger", 8'h02, 1'b0, 771, 3);
        run_trigger_test("odd_align", 8'h02, 1'b1, 772, 4);
        test_xor_page();
        test_retrigger_ignored();
        test_reset_abort();
        test_cpu_mux();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
